// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit
// Description : Execute-stage branch/jump resolver. Evaluates BEQ/BNE/BLT/BGE/
//               BLTU/BGEU/JAL/JALR, issues a registered PC redirect and link
//               write, flags misaligned targets, squashes FLUSH_DEPTH younger
//               instructions after a redirect and keeps saturating branch and
//               taken statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
   parameter int XLEN        = 32,
   parameter int FLUSH_DEPTH = 1,
   parameter int CNT_W       = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   input  logic [3:0]       i_op,
   input  logic [XLEN-1:0]  i_pc,
   input  logic [XLEN-1:0]  i_imm,
   input  logic [XLEN-1:0]  i_rs1,
   input  logic [XLEN-1:0]  i_rs2,
   output logic             o_redirect,
   output logic [XLEN-1:0]  o_target,
   output logic             o_link_we,
   output logic [XLEN-1:0]  o_link,
   output logic             o_squash,
   output logic             o_misalign,
   output logic             o_busy,
   output logic [CNT_W-1:0] o_branch_cnt,
   output logic [CNT_W-1:0] o_taken_cnt
);

   localparam logic [3:0]       C_OP_BEQ     = 4'd1;
   localparam logic [3:0]       C_OP_BNE     = 4'd2;
   localparam logic [3:0]       C_OP_BLT     = 4'd3;
   localparam logic [3:0]       C_OP_BGE     = 4'd4;
   localparam logic [3:0]       C_OP_BLTU    = 4'd5;
   localparam logic [3:0]       C_OP_BGEU    = 4'd6;
   localparam logic [3:0]       C_OP_JAL     = 4'd7;
   localparam logic [3:0]       C_OP_JALR    = 4'd8;
   localparam logic [3:0]       C_FLUSH_LOAD = 4'(FLUSH_DEPTH);
   localparam logic             C_USE_FLUSH  = (FLUSH_DEPTH > 0);
   localparam logic [CNT_W-1:0] C_CNT_MAX    = '1;
   localparam logic [XLEN-1:0]  C_FOUR       = XLEN'(4);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [3:0]        r_flush_cnt, w_flush_cnt_nxt;

   logic              r_redirect, r_link_we, r_misalign;
   logic [XLEN-1:0]   r_target, r_link;
   logic [CNT_W-1:0]  r_branch_cnt, r_taken_cnt;

   logic              w_accept, w_is_jump, w_taken, w_misalign, w_redirect;
   logic              w_lt_s, w_lt_u;
   logic [XLEN-1:0]   w_br_target, w_jalr_sum, w_target;

   // Only real branch/jump ops are evaluated, and only while not flushing.
   assign w_accept    = i_valid && (r_state == ST_IDLE) &&
                        (i_op >= C_OP_BEQ) && (i_op <= C_OP_JALR);
   assign w_is_jump   = (i_op == C_OP_JAL) || (i_op == C_OP_JALR);
   assign w_lt_s      = $signed(i_rs1) < $signed(i_rs2);
   assign w_lt_u      = i_rs1 < i_rs2;
   assign w_br_target = i_pc + i_imm;
   assign w_jalr_sum  = i_rs1 + i_imm;

   // Branch condition and target selection.
   always_comb begin
      w_taken  = 1'b0;
      w_target = w_br_target;
      case (i_op)
         C_OP_BEQ:  w_taken = (i_rs1 == i_rs2);
         C_OP_BNE:  w_taken = (i_rs1 != i_rs2);
         C_OP_BLT:  w_taken = w_lt_s;
         C_OP_BGE:  w_taken = !w_lt_s;
         C_OP_BLTU: w_taken = w_lt_u;
         C_OP_BGEU: w_taken = !w_lt_u;
         C_OP_JAL:  w_taken = 1'b1;
         C_OP_JALR: begin
            w_taken  = 1'b1;
            w_target = {w_jalr_sum[XLEN-1:1], 1'b0};
         end
         default:   w_taken = 1'b0;
      endcase
   end

   // A taken op to an unaligned address traps instead of redirecting.
   assign w_misalign = w_accept && w_taken && (w_target[1:0] != 2'b00);
   assign w_redirect = w_accept && w_taken && (w_target[1:0] == 2'b00);

   // FSM state and flush counter registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= ST_IDLE;
         r_flush_cnt <= 4'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_flush_cnt <= w_flush_cnt_nxt;
      end
   end

   // Next-state: enter FLUSH on a redirect, leave when the counter hits 1.
   always_comb begin
      w_state_nxt     = r_state;
      w_flush_cnt_nxt = r_flush_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_redirect && C_USE_FLUSH) begin
               w_state_nxt     = ST_FLUSH;
               w_flush_cnt_nxt = C_FLUSH_LOAD;
            end
         end
         ST_FLUSH: begin
            if (r_flush_cnt <= 4'd1) begin
               w_state_nxt     = ST_IDLE;
               w_flush_cnt_nxt = 4'd0;
            end else begin
               w_flush_cnt_nxt = r_flush_cnt - 4'd1;
            end
         end
         default: begin
            w_state_nxt     = ST_IDLE;
            w_flush_cnt_nxt = 4'd0;
         end
      endcase
   end

   // One-cycle result strobes; data buses are zeroed when their strobe is low.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_redirect <= 1'b0;
         r_target   <= '0;
         r_link_we  <= 1'b0;
         r_link     <= '0;
         r_misalign <= 1'b0;
      end else begin
         r_redirect <= w_redirect;
         r_target   <= w_redirect ? w_target : '0;
         r_link_we  <= w_accept && w_is_jump;
         r_link     <= (w_accept && w_is_jump) ? (i_pc + C_FOUR) : '0;
         r_misalign <= w_misalign;
      end
   end

   // Saturating statistics for the perf block.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_branch_cnt <= '0;
         r_taken_cnt  <= '0;
      end else begin
         if (w_accept && (r_branch_cnt != C_CNT_MAX)) begin
            r_branch_cnt <= r_branch_cnt + 1'b1;
         end
         if (w_redirect && (r_taken_cnt != C_CNT_MAX)) begin
            r_taken_cnt <= r_taken_cnt + 1'b1;
         end
      end
   end

   assign o_redirect   = r_redirect;
   assign o_target     = r_target;
   assign o_link_we    = r_link_we;
   assign o_link       = r_link;
   assign o_misalign   = r_misalign;
   assign o_squash     = (r_state == ST_FLUSH);
   assign o_busy       = (r_state == ST_FLUSH);
   assign o_branch_cnt = r_branch_cnt;
   assign o_taken_cnt  = r_taken_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolve_unit
// Description : Self-checking bench. Four instances with different flush
//               depths and counter widths share one stimulus stream; each has
//               its own behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic [3:0]  op;
   logic [31:0] pc, imm, rs1, rs2;

   logic        d_redirect [N];
   logic        d_link_we  [N];
   logic        d_squash   [N];
   logic        d_misalign [N];
   logic        d_busy     [N];
   logic [31:0] d_target   [N];
   logic [31:0] d_link     [N];
   logic [15:0] d_bcnt     [N];
   logic [15:0] d_tcnt     [N];

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state per instance
   int          m_sq       [N];
   int          m_bcnt     [N];
   int          m_tcnt     [N];
   logic        m_redirect [N];
   logic        m_link_we  [N];
   logic        m_misalign [N];
   logic [31:0] m_target   [N];
   logic [31:0] m_link     [N];

   always #5 clk = ~clk;

   function automatic int fd_of(input int k);
      case (k)
         0: return 1;
         1: return 3;
         2: return 0;
         default: return 4;
      endcase
   endfunction

   function automatic int cmax_of(input int k);
      case (k)
         1: return 3;
         3: return 7;
         default: return 65535;
      endcase
   endfunction

   for (genvar g = 0; g < N; g++) begin : g_dut
      localparam int FD = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 0 : 4;
      localparam int CW = (g == 1) ? 2 : (g == 3) ? 3 : 16;
      logic [CW-1:0] w_bc, w_tc;
      branch_resolve_unit #(.XLEN(32), .FLUSH_DEPTH(FD), .CNT_W(CW)) u_dut (
         .i_clk        (clk),
         .i_rst        (rst),
         .i_valid      (valid),
         .i_op         (op),
         .i_pc         (pc),
         .i_imm        (imm),
         .i_rs1        (rs1),
         .i_rs2        (rs2),
         .o_redirect   (d_redirect[g]),
         .o_target     (d_target[g]),
         .o_link_we    (d_link_we[g]),
         .o_link       (d_link[g]),
         .o_squash     (d_squash[g]),
         .o_misalign   (d_misalign[g]),
         .o_busy       (d_busy[g]),
         .o_branch_cnt (w_bc),
         .o_taken_cnt  (w_tc)
      );
      assign d_bcnt[g] = 16'(w_bc);
      assign d_tcnt[g] = 16'(w_tc);
   end

   // Architectural branch semantics straight from the ISA rules.
   function automatic void ref_eval(input logic [3:0] o, input logic [31:0] p,
                                    input logic [31:0] i, input logic [31:0] a,
                                    input logic [31:0] b, output bit tk,
                                    output logic [31:0] tg);
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      tg = p + i;
      case (o)
         4'd1: tk = (a == b);
         4'd2: tk = (a != b);
         4'd3: tk = (sa < sb);
         4'd4: tk = (sa >= sb);
         4'd5: tk = ({32'd0, a} < {32'd0, b});
         4'd6: tk = ({32'd0, a} >= {32'd0, b});
         4'd7: tk = 1'b1;
         4'd8: begin
            tk = 1'b1;
            tg = (a + i) & 32'hFFFF_FFFE;
         end
         default: tk = 1'b0;
      endcase
   endfunction

   // Advance every model by one clock edge using the inputs just applied.
   task automatic model_step();
      for (int k = 0; k < N; k++) begin
         bit          acc, tk;
         logic [31:0] tg;
         acc = valid && (m_sq[k] == 0) && (op >= 4'd1) && (op <= 4'd8);
         m_redirect[k] = 1'b0;
         m_link_we[k]  = 1'b0;
         m_misalign[k] = 1'b0;
         m_target[k]   = 32'd0;
         m_link[k]     = 32'd0;
         if (m_sq[k] > 0) m_sq[k] = m_sq[k] - 1;
         if (acc) begin
            ref_eval(op, pc, imm, rs1, rs2, tk, tg);
            if (m_bcnt[k] < cmax_of(k)) m_bcnt[k] = m_bcnt[k] + 1;
            if (op == 4'd7 || op == 4'd8) begin
               m_link_we[k] = 1'b1;
               m_link[k]    = pc + 32'd4;
            end
            if (tk) begin
               if (tg[1:0] != 2'b00) begin
                  m_misalign[k] = 1'b1;
               end else begin
                  m_redirect[k] = 1'b1;
                  m_target[k]   = tg;
                  if (m_tcnt[k] < cmax_of(k)) m_tcnt[k] = m_tcnt[k] + 1;
                  m_sq[k] = fd_of(k);
               end
            end
         end
         if (rst) begin
            m_sq[k] = 0; m_bcnt[k] = 0; m_tcnt[k] = 0;
            m_redirect[k] = 1'b0; m_link_we[k] = 1'b0; m_misalign[k] = 1'b0;
            m_target[k] = 32'd0; m_link[k] = 32'd0;
         end
      end
   endtask

   task automatic tick(input logic r, input logic v, input logic [3:0] o,
                       input logic [31:0] p, input logic [31:0] i,
                       input logic [31:0] a, input logic [31:0] b);
      rst = r; valid = v; op = o; pc = p; imm = i; rs1 = a; rs2 = b;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0);
   endtask

   task automatic do_reset();
      tick(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0);
   endtask

   task automatic test_reset();
      do_reset();
      for (int k = 0; k < N; k++) begin
         n_checks++;
         if ({d_redirect[k], d_link_we[k], d_squash[k], d_misalign[k], d_busy[k]} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_strobes[%0d]: got %b expected 00000", k,
                     {d_redirect[k], d_link_we[k], d_squash[k], d_misalign[k], d_busy[k]});
         end
         n_checks++;
         if ({d_target[k], d_link[k], d_bcnt[k], d_tcnt[k]} !== 96'd0) begin
            n_errors++;
            $display("FAIL reset_values[%0d]: target=%h link=%h bcnt=%0d tcnt=%0d expected all 0",
                     k, d_target[k], d_link[k], d_bcnt[k], d_tcnt[k]);
         end
      end
   endtask

   task automatic test_blt_signed();
      do_reset();
      tick(1'b0, 1'b1, 4'd3, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'd1);
      n_checks++;
      if (d_redirect[0] !== 1'b1 || d_target[0] !== 32'h120) begin
         n_errors++;
         $display("FAIL blt_redirect: got redirect=%b target=%h expected 1/00000120",
                  d_redirect[0], d_target[0]);
      end
      n_checks++;
      if (d_squash[0] !== 1'b1 || d_tcnt[0] !== 16'd1) begin
         n_errors++;
         $display("FAIL blt_squash_tcnt: got squash=%b tcnt=%0d expected 1/1", d_squash[0], d_tcnt[0]);
      end
      idle(1);
      n_checks++;
      if (d_squash[0] !== 1'b0 || d_redirect[0] !== 1'b0 || d_target[0] !== 32'd0) begin
         n_errors++;
         $display("FAIL blt_after: got squash=%b redirect=%b target=%h expected 0/0/0",
                  d_squash[0], d_redirect[0], d_target[0]);
      end
      idle(4);
      tick(1'b0, 1'b1, 4'd5, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'd1);
      n_checks++;
      if (d_redirect[0] !== 1'b0 || d_bcnt[0] !== 16'd2 || d_tcnt[0] !== 16'd1) begin
         n_errors++;
         $display("FAIL bltu_not_taken: got redirect=%b bcnt=%0d tcnt=%0d expected 0/2/1",
                  d_redirect[0], d_bcnt[0], d_tcnt[0]);
      end
   endtask

   task automatic test_flush_window();
      do_reset();
      tick(1'b0, 1'b1, 4'd1, 32'h200, 32'h10, 32'd5, 32'd5);
      for (int c = 1; c <= 3; c++) begin
         n_checks++;
         if (d_squash[1] !== 1'b1 || d_busy[1] !== 1'b1) begin
            n_errors++;
            $display("FAIL flush_cycle_%0d: got squash=%b busy=%b expected 1/1", c, d_squash[1], d_busy[1]);
         end
         tick(1'b0, 1'b1, 4'd2, 32'h300, 32'h40, 32'd1, 32'd2);
      end
      n_checks++;
      if (d_squash[1] !== 1'b0 || d_redirect[1] !== 1'b0 || d_bcnt[1] !== 16'd1) begin
         n_errors++;
         $display("FAIL flush_end: got squash=%b redirect=%b bcnt=%0d expected 0/0/1",
                  d_squash[1], d_redirect[1], d_bcnt[1]);
      end
   endtask

   task automatic test_jalr_misalign();
      do_reset();
      tick(1'b0, 1'b1, 4'd8, 32'h40, 32'd0, 32'h203, 32'd0);
      n_checks++;
      if (d_misalign[0] !== 1'b1 || d_link_we[0] !== 1'b1 || d_link[0] !== 32'h44) begin
         n_errors++;
         $display("FAIL jalr_misalign: got mis=%b link_we=%b link=%h expected 1/1/00000044",
                  d_misalign[0], d_link_we[0], d_link[0]);
      end
      n_checks++;
      if (d_redirect[0] !== 1'b0 || d_busy[0] !== 1'b0 || d_tcnt[0] !== 16'd0) begin
         n_errors++;
         $display("FAIL jalr_no_redirect: got redirect=%b busy=%b tcnt=%0d expected 0/0/0",
                  d_redirect[0], d_busy[0], d_tcnt[0]);
      end
   endtask

   task automatic test_jal_wrap();
      do_reset();
      tick(1'b0, 1'b1, 4'd7, 32'hFFFF_FFFC, 32'd8, 32'd0, 32'd0);
      n_checks++;
      if (d_redirect[0] !== 1'b1 || d_target[0] !== 32'h4 || d_link_we[0] !== 1'b1 || d_link[0] !== 32'h0) begin
         n_errors++;
         $display("FAIL jal_wrap: got redirect=%b target=%h link_we=%b link=%h expected 1/00000004/1/00000000",
                  d_redirect[0], d_target[0], d_link_we[0], d_link[0]);
      end
   endtask

   task automatic test_reset_mid_flush();
      do_reset();
      tick(1'b0, 1'b1, 4'd1, 32'h80, 32'h8, 32'd7, 32'd7);
      idle(1);
      n_checks++;
      if (d_busy[3] !== 1'b1) begin
         n_errors++;
         $display("FAIL midflush_busy: got busy=%b expected 1", d_busy[3]);
      end
      tick(1'b1, 1'b1, 4'd1, 32'h80, 32'h8, 32'd7, 32'd7);
      n_checks++;
      if (d_squash[3] !== 1'b0 || d_busy[3] !== 1'b0 || d_bcnt[3] !== 16'd0 || d_tcnt[3] !== 16'd0 ||
          d_redirect[3] !== 1'b0) begin
         n_errors++;
         $display("FAIL midflush_reset: got squash=%b busy=%b bcnt=%0d tcnt=%0d redirect=%b expected all 0",
                  d_squash[3], d_busy[3], d_bcnt[3], d_tcnt[3], d_redirect[3]);
      end
      tick(1'b0, 1'b1, 4'd1, 32'h80, 32'h8, 32'd7, 32'd7);
      n_checks++;
      if (d_redirect[3] !== 1'b1 || d_target[3] !== 32'h88 || d_bcnt[3] !== 16'd1 ||
          d_tcnt[3] !== 16'd1 || d_busy[3] !== 1'b1) begin
         n_errors++;
         $display("FAIL midflush_resume: got redirect=%b target=%h bcnt=%0d tcnt=%0d busy=%b expected 1/00000088/1/1/1",
                  d_redirect[3], d_target[3], d_bcnt[3], d_tcnt[3], d_busy[3]);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      tick(1'b0, 1'b1, 4'd1, 32'h300, 32'h40, 32'd1, 32'd2);
      n_checks++;
      if (d_redirect[0] !== 1'b0 || d_busy[0] !== 1'b0 || d_bcnt[0] !== 16'd1) begin
         n_errors++;
         $display("FAIL b2b_not_taken: got redirect=%b busy=%b bcnt=%0d expected 0/0/1",
                  d_redirect[0], d_busy[0], d_bcnt[0]);
      end
      tick(1'b0, 1'b1, 4'd2, 32'h300, 32'h40, 32'd1, 32'd2);
      n_checks++;
      if (d_redirect[0] !== 1'b1 || d_target[0] !== 32'h340 || d_bcnt[0] !== 16'd2) begin
         n_errors++;
         $display("FAIL b2b_taken: got redirect=%b target=%h bcnt=%0d expected 1/00000340/2",
                  d_redirect[0], d_target[0], d_bcnt[0]);
      end
      tick(1'b0, 1'b1, 4'd7, 32'h500, 32'h10, 32'd0, 32'd0);
      n_checks++;
      if (d_redirect[2] !== 1'b1 || d_target[2] !== 32'h510 || d_busy[2] !== 1'b0 ||
          d_squash[2] !== 1'b0 || d_bcnt[2] !== 16'd3) begin
         n_errors++;
         $display("FAIL fd0_b2b: got redirect=%b target=%h busy=%b squash=%b bcnt=%0d expected 1/00000510/0/0/3",
                  d_redirect[2], d_target[2], d_busy[2], d_squash[2], d_bcnt[2]);
      end
   endtask

   task automatic test_saturate();
      do_reset();
      repeat (5) begin
         tick(1'b0, 1'b1, 4'd7, 32'h1000, 32'h100, 32'd0, 32'd0);
         idle(4);
      end
      n_checks++;
      if (d_tcnt[1] !== 16'd3 || d_bcnt[1] !== 16'd3) begin
         n_errors++;
         $display("FAIL sat_cw2: got tcnt=%0d bcnt=%0d expected 3/3", d_tcnt[1], d_bcnt[1]);
      end
      n_checks++;
      if (d_tcnt[3] !== 16'd5 || d_bcnt[3] !== 16'd5) begin
         n_errors++;
         $display("FAIL sat_cw3: got tcnt=%0d bcnt=%0d expected 5/5", d_tcnt[3], d_bcnt[3]);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         logic        r_v;
         logic [3:0]  r_op;
         logic [31:0] r_pc, r_imm, r_a, r_b;
         r_v   = ($urandom_range(0, 9) < 8);
         r_op  = 4'($urandom_range(0, 15));
         r_pc  = $urandom & 32'hFFFF_FFFC;
         r_imm = ($urandom_range(0, 9) < 7) ? ($urandom & 32'hFFFF_FFFC) : 32'($urandom);
         r_a   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : 32'($urandom);
         r_b   = ($urandom_range(0, 2) == 0) ? r_a : 32'($urandom);
         tick(($urandom_range(0, 199) == 0), r_v, r_op, r_pc, r_imm, r_a, r_b);
         for (int k = 0; k < N; k++) begin
            logic sq;
            sq = (m_sq[k] > 0);
            n_checks++;
            if ({d_redirect[k], d_link_we[k], d_misalign[k], d_squash[k], d_busy[k]} !==
                {m_redirect[k], m_link_we[k], m_misalign[k], sq, sq}) begin
               n_errors++;
               $display("FAIL rand_strobes[%0d] cyc %0d: got %b expected %b", k, c,
                        {d_redirect[k], d_link_we[k], d_misalign[k], d_squash[k], d_busy[k]},
                        {m_redirect[k], m_link_we[k], m_misalign[k], sq, sq});
            end
            n_checks++;
            if (d_target[k] !== m_target[k] || d_link[k] !== m_link[k]) begin
               n_errors++;
               $display("FAIL rand_data[%0d] cyc %0d: got target=%h link=%h expected %h/%h", k, c,
                        d_target[k], d_link[k], m_target[k], m_link[k]);
            end
            n_checks++;
            if (d_bcnt[k] !== 16'(m_bcnt[k]) || d_tcnt[k] !== 16'(m_tcnt[k])) begin
               n_errors++;
               $display("FAIL rand_cnt[%0d] cyc %0d: got bcnt=%0d tcnt=%0d expected %0d/%0d", k, c,
                        d_bcnt[k], d_tcnt[k], m_bcnt[k], m_tcnt[k]);
            end
         end
      end
   endtask

   initial begin
      for (int k = 0; k < N; k++) begin
         m_sq[k] = 0; m_bcnt[k] = 0; m_tcnt[k] = 0;
         m_redirect[k] = 1'b0; m_link_we[k] = 1'b0; m_misalign[k] = 1'b0;
         m_target[k] = 32'd0; m_link[k] = 32'd0;
      end
      rst = 1'b1; valid = 1'b0; op = 4'd0;
      pc = 32'd0; imm = 32'd0; rs1 = 32'd0; rs2 = 32'd0;
      test_reset();
      test_blt_signed();
      test_flush_window();
      test_jalr_misalign();
      test_jal_wrap();
      test_reset_mid_flush();
      test_back_to_back();
      test_saturate();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
